emif_avmm_rr_arbiter: RTL

- Shares the single EMIF DDR4 Avalon-MM user port between two requesters: m0 is the UART-TL bridge and m1 is the on-chip pattern/BIST engine.
- Round-robin command arbitration; a write burst locks the grant until its last beat.
- Read responses are routed back to their issuer through an in-order tag queue.
- Sits between the requesters and the memory subsystem, in the same clock domain as the EMIF user clock.

---
 rtl/emif_arb_pkg.sv | 29 ++
 rtl/emif_arb_tag_fifo.sv | 51 +++++
 rtl/emif_avmm_rr_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/emif_arb_pkg.sv
// Shared types for the EMIF Avalon-MM round-robin arbiter.
// Tag entries record the issuer and beat count of each outstanding read.
package emif_arb_pkg;

   localparam int TAG_BURST_W = 7;

   localparam logic ID_M0 = 1'b0;
   localparam logic ID_M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WBURST
   } state_t;

   typedef struct packed {
      logic                   id;
      logic [TAG_BURST_W-1:0] beats;
   } tag_t;

   // A burstcount of 0 behaves as a single beat.
   function automatic logic last_beat(
      input logic [TAG_BURST_W-1:0] cnt,
      input logic [TAG_BURST_W-1:0] beats
   );
      return ({1'b0, cnt} + (TAG_BURST_W+1)'(1)) >= {1'b0, beats};
   endfunction

endpackage

// File: rtl/emif_arb_tag_fifo.sv
// In-order queue of outstanding read tags.
// Head is valid whenever empty is low.
module emif_arb_tag_fifo
   import emif_arb_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  tag_t push_tag,
   input  logic pop,
   output tag_t head,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   tag_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/emif_avmm_rr_arbiter.sv
// Round-robin arbiter sharing one EMIF Avalon-MM port between two masters.
// Write bursts hold the grant; read data is steered back via a tag queue.
module emif_avmm_rr_arbiter
   import emif_arb_pkg::*;
#(
   parameter int ADDR_W    = 27,
   parameter int DATA_W    = 512,
   parameter int BURST_W   = 7,
   parameter int TAG_DEPTH = 16
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic                cal_success,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic [BURST_W-1:0]  m0_burstcount,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [BURST_W-1:0]  m1_burstcount,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   output logic [BURST_W-1:0]  s_burstcount,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   input  logic                s_readdatavalid,
   output logic                rsp_err
);

   state_t               state, state_d;
   logic                 grant_id, grant_d;
   logic                 last_grant, last_d;
   logic [BURST_W-1:0]   remaining, rem_d;
   logic                 cal_q;
   logic                 g_read, g_write, busy, accept;
   logic                 elig0, elig1;
   logic                 push, pop, full, empty, rsp_last;
   tag_t                 head, push_tag;
   logic [TAG_BURST_W-1:0] beat_cnt;
   logic                 rdv0_q, rdv1_q;
   logic [DATA_W-1:0]    rdata_q;

   always_comb begin
      g_read         = grant_id ? m1_read : m0_read;
      g_write        = grant_id ? m1_write : m0_write;
      s_address      = grant_id ? m1_address : m0_address;
      s_writedata    = grant_id ? m1_writedata : m0_writedata;
      s_byteenable   = grant_id ? m1_byteenable : m0_byteenable;
      s_burstcount   = grant_id ? m1_burstcount : m0_burstcount;
      busy           = (state != IDLE);
      s_read         = (state == GRANT) & g_read & ~full;
      s_write        = busy & g_write;
      accept         = (s_read | s_write) & ~s_waitrequest;
      m0_waitrequest = ~(busy & (grant_id == ID_M0)) | s_waitrequest;
      m1_waitrequest = ~(busy & (grant_id == ID_M1)) | s_waitrequest;
      push           = (state == GRANT) & accept & s_read;
      push_tag       = '{id: grant_id, beats: TAG_BURST_W'(s_burstcount)};
   end

   // A read only competes while a tag slot is free.
   assign elig0 = cal_q & (m0_write | (m0_read & ~full));
   assign elig1 = cal_q & (m1_write | (m1_read & ~full));

   always_comb begin
      state_d = state;
      grant_d = grant_id;
      last_d  = last_grant;
      rem_d   = remaining;
      unique case (state)
         IDLE: begin
            if (elig0 | elig1) begin
               state_d = GRANT;
               grant_d = (elig0 & elig1) ? ~last_grant : elig1;
            end
         end
         GRANT: begin
            if (accept) begin
               if (s_write && (s_burstcount > BURST_W'(1))) begin
                  rem_d   = s_burstcount - BURST_W'(1);
                  state_d = WBURST;
               end else begin
                  last_d  = grant_id;
                  state_d = IDLE;
               end
            end
         end
         WBURST: begin
            if (accept) begin
               rem_d = remaining - BURST_W'(1);
               if (remaining == BURST_W'(1)) begin
                  last_d  = grant_id;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rsp_last = last_beat(beat_cnt, head.beats);
   assign pop      = s_readdatavalid & ~empty & rsp_last;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state      <= IDLE;
         grant_id   <= ID_M0;
         last_grant <= ID_M1;
         remaining  <= '0;
         cal_q      <= 1'b0;
         beat_cnt   <= '0;
         rdv0_q     <= 1'b0;
         rdv1_q     <= 1'b0;
         rdata_q    <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state      <= state_d;
         grant_id   <= grant_d;
         last_grant <= last_d;
         remaining  <= rem_d;
         cal_q      <= cal_success;
         rdv0_q     <= s_readdatavalid & ~empty & (head.id == ID_M0);
         rdv1_q     <= s_readdatavalid & ~empty & (head.id == ID_M1);
         if (s_readdatavalid) begin
            rdata_q <= s_readdata;
            if (empty) rsp_err <= 1'b1;
            else beat_cnt <= rsp_last ? '0 : beat_cnt + TAG_BURST_W'(1);
         end
      end
   end

   assign m0_readdata      = rdata_q;
   assign m1_readdata      = rdata_q;
   assign m0_readdatavalid = rdv0_q;
   assign m1_readdatavalid = rdv1_q;

   emif_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk      (clk_clk),
      .rst      (reset_reset),
      .push     (push),
      .push_tag (push_tag),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

endmodule
